udp_loopback_checker: RTL
=========================

Name: udp_loopback_checker

Overview:
- Initiator/checker for the UDP echo test path: builds one request packet, hands it to the UDP TX byte stream, then consumes the reply from the UDP RX byte stream.
- The responder answers a request whose last byte is N with bytes N, N-1, ..., 0; this block checks that sequence byte by byte.
- Reports pass/fail, error count and byte count to the control/debug register bank.

Parameters:
- REQ_LEN, 4, request packet length in bytes (1..255); last byte carries the seed.
- ERR_W, 8, width of the saturating error counter.
- TIMEOUT_CYCLES, 1000000, idle-cycle limit while awaiting or receiving the reply (optional feature only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; ignored unless in IDLE.
- seed  in  8  counter start value; sampled when start is accepted.
- dataout  out  8  request byte to UDP TX.
- dataout_valid  out  1  dataout is valid.
- dataout_ready  in  1  TX accepts a byte.
- dataout_lastbyte  out  1  marks the final request byte.
- send  out  1  one-cycle packet-commit pulse to TX.
- datain  in  8  reply byte from UDP RX.
- datain_valid  in  1  datain is valid.
- datain_ready  out  1  checker accepts a reply byte.
- datain_lastbyte  in  1  marks the final reply byte.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  result of the last test; held until the next start.
- err_count  out  ERR_W  mismatches in the last test; saturates at all-ones.
- rx_count  out  9  reply bytes consumed in the last test.
- timeout  out  1  last test ended by timeout.
- status  out  8  {state[2:0], datain_valid, dataout_ready, rx_count[2:0]}.

Behaviour:
- Handshake: a byte transfers on a rising edge where valid and ready are both high. The data, valid and lastbyte signals of the sender are held stable while valid is high and ready is low.
- Reset: dataout=0, dataout_valid=0, dataout_lastbyte=0, send=0, datain_ready=0, busy=0, done=0, pass=0, err_count=0, rx_count=0, timeout=0, state=IDLE.
- IDLE:
  - On start: latch seed, clear err_count, rx_count and timeout, set busy, go to SEND.
  - dataout_valid is asserted in the cycle after start.
- SEND:
  - Request byte i is i[7:0] for i < REQ_LEN-1; byte REQ_LEN-1 is the seed, with dataout_lastbyte=1.
  - On transfer of the last byte: send=1 for exactly one cycle, dataout_valid drops, go to WAIT.
  - REQ_LEN=1 sends only the seed byte.
- WAIT: datain_ready=1; the expected value exp equals the seed; the first accepted byte moves the FSM to RECV and is checked.
- RECV: datain_ready=1; each accepted byte is checked as follows.
  - If datain != exp, err_count increments (saturating).
  - rx_count increments, saturating at 511.
  - exp decrements mod 256.
  - Lastbyte rule: datain_lastbyte must be 1 exactly when the checked exp is 0. Any violation adds one error.
  - The test ends on the byte with datain_lastbyte=1, or on the byte where exp was 0, whichever comes first.
- DONE (1 cycle):
  - datain_ready=0, busy=0, done=1.
  - pass=1 iff err_count==0, rx_count==seed+1 and timeout==0.
  - Return to IDLE.
- Simultaneous events:
  - A start during busy is ignored.
  - A datain_valid while in IDLE or SEND is not consumed (datain_ready=0).
- A reset mid-packet aborts immediately and no send is issued. TX/RX flushing is the stack's responsibility.
- Expected reply length is seed+1 (1..256 bytes); a seed of 0 expects a single byte 0 with lastbyte set.

Optional Feature:
- Macro: LOOPCHK_TIMEOUT_EN.
- Enabled:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on each accepted reply byte and on entry to WAIT, and increments each cycle in WAIT and RECV.
  - On reaching TIMEOUT_CYCLES: timeout=1, go to DONE, pass=0.
- Disabled: the block waits indefinitely; timeout is tied to 0; no counter logic is present.

Decomposition:
- Package loopchk_pkg: state encoding (IDLE=0, SEND=1, WAIT=2, RECV=3, DONE=4), the rx_count width, and a default REQ_LEN constant.
- One sub-module, loopchk_byte_checker: holds exp/err_count/rx_count. Its inputs are load and accept strobes, the data byte and lastbyte. Its outputs are mismatch, end-of-packet, and the counters.

Test Plan:
- seed=5, REQ_LEN=4, dataout_ready=1, correct reply 5,4,3,2,1,0 with lastbyte on 0 -> TX bytes 00,01,02,05 with lastbyte on 05; send pulses once; pass=1, err_count=0, rx_count=6.
- seed=3, reply 3,4,1,0 -> err_count=1, pass=0, rx_count=4.
- seed=3, reply 3,2 with lastbyte on 2 -> early end, err_count=1, rx_count=2, pass=0. Also seed=0, reply 00 with lastbyte -> pass=1, rx_count=1.
- dataout_ready toggled 1,0,0,1 during SEND -> dataout held stable while stalled, no byte skipped or duplicated; datain_valid with gaps in RECV -> pass=1.
- Reset asserted mid-SEND at byte 2 -> all outputs return to reset values immediately, no send pulse; a following start with seed=2 runs clean and passes.
- With LOOPCHK_TIMEOUT_EN and TIMEOUT_CYCLES=100, no reply -> done after 100 cycles in WAIT, timeout=1, pass=0. Without the macro -> busy stays high.

Source files
------------

// File: rtl/loopchk_pkg.sv
// Shared types and constants for the UDP loopback checker.
package loopchk_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int RX_CNT_W    = 9;
    localparam int REQ_LEN_DEF = 4;

endpackage

// File: rtl/udp_loopback_checker_if.sv
// TX/RX byte-stream handshake bundle between the loopback checker (master) and the UDP stack (slave).
interface udp_loopback_checker_if;
    logic [7:0] dataout;
    logic       dataout_valid;
    logic       dataout_ready;
    logic       dataout_lastbyte;
    logic       send;
    logic [7:0] datain;
    logic       datain_valid;
    logic       datain_ready;
    logic       datain_lastbyte;

    modport master (
        output dataout, dataout_valid, dataout_lastbyte, send, datain_ready,
        input  dataout_ready, datain, datain_valid, datain_lastbyte
    );

    modport slave (
        input  dataout, dataout_valid, dataout_lastbyte, send, datain_ready,
        output dataout_ready, datain, datain_valid, datain_lastbyte
    );
endinterface

// File: rtl/loopchk_byte_checker.sv
// Reply checker: tracks the expected countdown byte, a saturating error count and the byte count.
module loopchk_byte_checker
    import loopchk_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [7:0]          seed,
    input  logic                accept,
    input  logic [7:0]          data,
    input  logic                lastbyte,
    output logic                mismatch,
    output logic                eop,
    output logic [ERR_W-1:0]    err_count,
    output logic [RX_CNT_W-1:0] rx_count
);
    logic [7:0]   exp_q;
    logic         exp_zero;
    logic         data_err;
    logic         last_err;
    logic [1:0]   err_inc;
    logic [ERR_W:0] err_sum;

    assign exp_zero = (exp_q == 8'd0);
    assign data_err = (data != exp_q);
    assign last_err = (lastbyte != exp_zero);
    assign mismatch = data_err | last_err;
    assign eop      = lastbyte | exp_zero;

    // A byte can carry both a data and a lastbyte violation, each counted separately
    assign err_inc = {1'b0, data_err} + {1'b0, last_err};
    assign err_sum = (ERR_W+1)'(err_count) + (ERR_W+1)'(err_inc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q     <= '0;
            err_count <= '0;
            rx_count  <= '0;
        end else if (load) begin
            exp_q     <= seed;
            err_count <= '0;
            rx_count  <= '0;
        end else if (accept) begin
            exp_q     <= exp_q - 8'd1;
            err_count <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
            if (rx_count != '1)
                rx_count <= rx_count + 1'b1;
        end
    end
endmodule

// File: rtl/udp_loopback_checker.sv
// UDP echo test initiator: sends one request, checks the N..0 countdown reply.
// Optional reply timeout enabled by defining LOOPCHK_TIMEOUT_EN.
module udp_loopback_checker
    import loopchk_pkg::*;
#(
    parameter int REQ_LEN        = REQ_LEN_DEF,
    parameter int ERR_W          = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            seed,
    udp_loopback_checker_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [RX_CNT_W-1:0]   rx_count,
    output logic                  timeout,
    output logic [7:0]            status
);
    state_t     state_q, state_d;
    logic [7:0] seed_q;
    logic [7:0] idx_q;
    logic       send_q;
    logic       pass_q;
    logic       timeout_q;
    logic       load, accept, tx_fire, tx_last, in_send, in_rx;
    logic       eop, tmo_hit, pass_now;
    logic       unused_mismatch;

    assign in_send = (state_q == SEND);
    assign in_rx   = (state_q == WAIT) || (state_q == RECV);
    assign tx_last = (idx_q == 8'(REQ_LEN-1));
    assign tx_fire = in_send && bus.dataout_ready;
    assign accept  = in_rx && bus.datain_valid;

    assign bus.dataout          = in_send ? (tx_last ? seed_q : idx_q) : '0;
    assign bus.dataout_valid    = in_send;
    assign bus.dataout_lastbyte = in_send && tx_last;
    assign bus.send             = send_q;
    assign bus.datain_ready     = in_rx;

    assign busy     = in_send || in_rx;
    assign done     = (state_q == DONE);
    assign pass_now = (err_count == '0) && (rx_count == {1'b0, seed_q} + 9'd1) && !timeout_q;
    assign pass     = done ? pass_now : pass_q;
    assign timeout  = timeout_q;
    assign status   = {3'(state_q), bus.datain_valid, bus.dataout_ready, rx_count[2:0]};

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: if (tx_fire && tx_last) state_d = WAIT;
            WAIT, RECV: begin
                if (accept)
                    state_d = eop ? DONE : RECV;
                else if (tmo_hit)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            seed_q  <= '0;
            idx_q   <= '0;
            send_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            send_q  <= tx_fire && tx_last;
            if (load) begin
                seed_q <= seed;
                idx_q  <= '0;
                pass_q <= 1'b0;
            end else if (tx_fire && !tx_last) begin
                idx_q <= idx_q + 8'd1;
            end
            if (done)
                pass_q <= pass_now;
        end
    end

`ifdef LOOPCHK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Fires on the cycle the idle count would reach TIMEOUT_CYCLES
    assign tmo_hit = in_rx && !bus.datain_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((tx_fire && tx_last) || accept)
                tmo_cnt <= '0;
            else if (in_rx)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (load)
                timeout_q <= 1'b0;
            else if (tmo_hit)
                timeout_q <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_hit   = 1'b0;
    assign timeout_q = 1'b0;
`endif

    loopchk_byte_checker #(.ERR_W(ERR_W)) u_checker (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (seed),
        .accept    (accept),
        .data      (bus.datain),
        .lastbyte  (bus.datain_lastbyte),
        .mismatch  (unused_mismatch),
        .eop       (eop),
        .err_count (err_count),
        .rx_count  (rx_count)
    );
endmodule
